// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//
// APB completer in front of a single-port synchronous memory. Each APB
// transfer that lands inside the memory window becomes one single-cycle
// memory request. Read data comes back one cycle after the request and is
// returned to the APB requester with o_pready. Addresses outside the window
// complete immediately with o_pslverr and never touch the memory.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_psel            APB select
//   i_penable         APB access phase
//   i_pwrite          1 = write, 0 = read
//   i_paddr           APB word address
//   i_pwdata          APB write data
//   o_prdata          APB read data (captured read or 0 on error)
//   o_pready          transfer complete, one-cycle strobe
//   o_pslverr         error response, meaningful only with o_pready
//   o_mem_en          memory enable, one-cycle pulse
//   o_mem_wr          memory write strobe, qualified by o_mem_en
//   o_mem_addr        memory word address
//   o_mem_data_w      memory write data
//   i_mem_data_r      memory read data, valid the cycle after o_mem_en
//
// State table
//   state  | meaning
//   IDLE   | waiting for an APB setup phase
//   REQ    | memory request on the bus (o_mem_en high this cycle)
//   CAPT   | read data arriving from memory, captured at end of cycle
//   RESP   | o_pready high for one cycle, o_pslverr per range check
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int                     PADDR_WIDTH    = 32,
    parameter int                     MEM_ADDR_WIDTH = 16,
    parameter int                     DATA_WIDTH     = 16,
    parameter logic [PADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic                      i_pwrite,
    input  logic [PADDR_WIDTH-1:0]    i_paddr,
    input  logic [DATA_WIDTH-1:0]     i_pwdata,
    output logic [DATA_WIDTH-1:0]     o_prdata,
    output logic                      o_pready,
    output logic                      o_pslverr,
    output logic                      o_mem_en,
    output logic                      o_mem_wr,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_data_w,
    input  logic [DATA_WIDTH-1:0]     i_mem_data_r
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Largest in-window offset, i.e. 2^MEM_ADDR_WIDTH - 1 at APB width.
    localparam logic [PADDR_WIDTH-1:0] WIN_LAST = PADDR_WIDTH'({MEM_ADDR_WIDTH{1'b1}});

    state_t                    state;
    state_t                    state_nxt;

    logic                      setup;
    logic [PADDR_WIDTH-1:0]    offset;
    logic                      addr_hit;

    logic [DATA_WIDTH-1:0]     prdata_nxt;
    logic                      pready_nxt;
    logic                      pslverr_nxt;
    logic                      mem_en_nxt;
    logic                      mem_wr_nxt;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0]     mem_data_w_nxt;

    assign setup  = i_psel & ~i_penable;
    assign offset = i_paddr - BASE_ADDR;

    // Range check on the full-width offset: addresses that would alias into
    // the window after truncation to MEM_ADDR_WIDTH are still errors.
    assign addr_hit = (i_paddr >= BASE_ADDR) && (offset <= WIN_LAST);

    // Every output is registered, so the comb process computes the value each
    // output takes in the state being entered. o_mem_wr/addr/data_w double as
    // the latched request; they only reload on an accepted in-window setup.
    always_comb begin
        state_nxt      = state;
        prdata_nxt     = o_prdata;
        pready_nxt     = 1'b0;
        pslverr_nxt    = 1'b0;
        mem_en_nxt     = 1'b0;
        mem_wr_nxt     = o_mem_wr;
        mem_addr_nxt   = o_mem_addr;
        mem_data_w_nxt = o_mem_data_w;

        case (state)
            S_IDLE: begin
                if (setup) begin
                    if (addr_hit) begin
                        state_nxt      = S_REQ;
                        mem_en_nxt     = 1'b1;
                        mem_wr_nxt     = i_pwrite;
                        mem_addr_nxt   = offset[MEM_ADDR_WIDTH-1:0];
                        mem_data_w_nxt = i_pwdata;
                    end else begin
                        state_nxt   = S_RESP;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = 1'b1;
                        prdata_nxt  = '0;
                    end
                end
            end

            S_REQ: begin
                if (!i_psel) begin
                    state_nxt = S_IDLE;
                end else if (o_mem_wr) begin
                    state_nxt  = S_RESP;
                    pready_nxt = 1'b1;
                end else begin
                    state_nxt = S_CAPT;
                end
            end

            S_CAPT: begin
                if (!i_psel) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt  = S_RESP;
                    pready_nxt = 1'b1;
                    prdata_nxt = i_mem_data_r;
                end
            end

            S_RESP: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            o_prdata     <= '0;
            o_pready     <= 1'b0;
            o_pslverr    <= 1'b0;
            o_mem_en     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data_w <= '0;
        end else begin
            state        <= state_nxt;
            o_prdata     <= prdata_nxt;
            o_pready     <= pready_nxt;
            o_pslverr    <= pslverr_nxt;
            o_mem_en     <= mem_en_nxt;
            o_mem_wr     <= mem_wr_nxt;
            o_mem_addr   <= mem_addr_nxt;
            o_mem_data_w <= mem_data_w_nxt;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Two completers share one APB bus: dut0 with its window at 0x0000_0000 and
// dut1 with its window at 0x0001_0000. Each has its own memory model. Every
// transfer is predicted for both completers; the predictions go into one
// scoreboard queue per completer and are popped when that completer raises
// o_pready.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_mem_slave;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0001_0000;

    typedef struct {
        int          lat;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [15:0] pwdata;

    logic [15:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;
    logic        mem_en0, mem_en1;
    logic        mem_wr0, mem_wr1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [15:0] mem_data_w0, mem_data_w1;
    logic [15:0] mem_data_r0, mem_data_r1;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];

    logic [15:0] ref0 [int];
    logic [15:0] ref1 [int];
    logic [15:0] last_rd [2];

    exp_t sb0 [$];
    exp_t sb1 [$];

    int n_vec = 0;
    int n_err = 0;
    int en_cnt0 = 0;
    int en_cnt1 = 0;

    always #5 clk = ~clk;

    apb_mem_slave #(
        .PADDR_WIDTH(32), .MEM_ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR(BASE0)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable),
        .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
        .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0),
        .o_mem_en(mem_en0), .o_mem_wr(mem_wr0), .o_mem_addr(mem_addr0),
        .o_mem_data_w(mem_data_w0), .i_mem_data_r(mem_data_r0)
    );

    apb_mem_slave #(
        .PADDR_WIDTH(32), .MEM_ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR(BASE1)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable),
        .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
        .o_prdata(prdata1), .o_pready(pready1), .o_pslverr(pslverr1),
        .o_mem_en(mem_en1), .o_mem_wr(mem_wr1), .o_mem_addr(mem_addr1),
        .o_mem_data_w(mem_data_w1), .i_mem_data_r(mem_data_r1)
    );

    // Read-first synchronous single-port memories.
    always @(posedge clk) begin
        if (mem_en0) begin
            if (mem_wr0) mem0[mem_addr0] <= mem_data_w0;
            mem_data_r0 <= mem0[mem_addr0];
        end
        if (mem_en1) begin
            if (mem_wr1) mem1[mem_addr1] <= mem_data_w1;
            mem_data_r1 <= mem1[mem_addr1];
        end
    end

    always @(negedge clk) begin
        if (mem_en0) en_cnt0++;
        if (mem_en1) en_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict(input int d, input logic [31:0] addr, input bit wr,
                           input logic [15:0] wd, output exp_t e, output bit hit,
                           output logic [15:0] off);
        logic [32:0] a, b, diff;
        logic [15:0] rd;
        a    = {1'b0, addr};
        b    = {1'b0, (d == 1) ? BASE1 : BASE0};
        diff = a - b;
        hit  = (a >= b) && (diff <= 33'h0_FFFF);
        off  = diff[15:0];
        e.err = !hit;
        e.lat = !hit ? 1 : (wr ? 2 : 3);
        if (!hit) begin
            e.rdata    = 16'h0;
            last_rd[d] = 16'h0;
        end else if (wr) begin
            e.rdata = last_rd[d];
            if (d == 0) ref0[int'(off)] = wd;
            else        ref1[int'(off)] = wd;
        end else begin
            if (d == 0) rd = ref0.exists(int'(off)) ? ref0[int'(off)] : 16'h0;
            else        rd = ref1.exists(int'(off)) ? ref1[int'(off)] : 16'h0;
            e.rdata    = rd;
            last_rd[d] = rd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // Complete one APB transfer. Returns #1 after the edge that starts the
    // last RESP cycle, so the next call issues its setup back-to-back.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [15:0] wd,
                        input string tag);
        exp_t        e0, e1, e;
        bit          hit0, hit1, got0, got1;
        logic [15:0] off0, off1;
        predict(0, addr, wr, wd, e0, hit0, off0);
        predict(1, addr, wr, wd, e1, hit1, off1);
        sb0.push_back(e0);
        sb1.push_back(e1);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;

        check({tag, " d0 mem_en"}, {31'b0, mem_en0}, {31'b0, hit0});
        if (hit0) begin
            check({tag, " d0 mem_wr"}, {31'b0, mem_wr0}, {31'b0, wr});
            check({tag, " d0 mem_addr"}, {16'b0, mem_addr0}, {16'b0, off0});
            if (wr) check({tag, " d0 mem_data_w"}, {16'b0, mem_data_w0}, {16'b0, wd});
        end
        check({tag, " d1 mem_en"}, {31'b0, mem_en1}, {31'b0, hit1});
        if (hit1) begin
            check({tag, " d1 mem_wr"}, {31'b0, mem_wr1}, {31'b0, wr});
            check({tag, " d1 mem_addr"}, {16'b0, mem_addr1}, {16'b0, off1});
        end

        got0 = 1'b0;
        got1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (pready0 && !got0) begin
                got0 = 1'b1;
                e = sb0.pop_front();
                check({tag, " d0 latency"}, c, e.lat);
                check({tag, " d0 pslverr"}, {31'b0, pslverr0}, {31'b0, e.err});
                check({tag, " d0 prdata"}, {16'b0, prdata0}, {16'b0, e.rdata});
            end
            if (pready1 && !got1) begin
                got1 = 1'b1;
                e = sb1.pop_front();
                check({tag, " d1 latency"}, c, e.lat);
                check({tag, " d1 pslverr"}, {31'b0, pslverr1}, {31'b0, e.err});
                check({tag, " d1 prdata"}, {16'b0, prdata1}, {16'b0, e.rdata});
            end
            if (got0 && got1) break;
        end
        check({tag, " d0 pready seen"}, {31'b0, got0}, 32'd1);
        check({tag, " d1 pready seen"}, {31'b0, got1}, 32'd1);
        if (!got0) e = sb0.pop_front();
        if (!got1) e = sb1.pop_front();
    endtask

    initial begin
        int cnt0, cnt1;
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 16'h0;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;

        // Reset then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst prdata", {16'b0, prdata0}, 32'h0);
        check("rst pready", {31'b0, pready0}, 32'h0);
        check("rst pslverr", {31'b0, pslverr0}, 32'h0);
        check("rst mem_en", {31'b0, mem_en0}, 32'h0);
        check("rst mem_wr", {31'b0, mem_wr0}, 32'h0);
        check("rst mem_addr", {16'b0, mem_addr0}, 32'h0);
        check("rst mem_data_w", {16'b0, mem_data_w0}, 32'h0);
        check("rst d1 pready", {31'b0, pready1}, 32'h0);
        idle(3);
        check("idle no mem_en d0", en_cnt0, 0);
        check("idle no mem_en d1", en_cnt1, 0);

        // Write hit, hold of request fields, read hit.
        xfer(32'h0000_0010, 1'b1, 16'hBEEF, "wr_hit");
        idle(2);
        check("hold mem_en", {31'b0, mem_en0}, 32'h0);
        check("hold mem_wr", {31'b0, mem_wr0}, 32'h1);
        check("hold mem_addr", {16'b0, mem_addr0}, 32'h0010);
        check("hold mem_data_w", {16'b0, mem_data_w0}, 32'hBEEF);
        xfer(32'h0000_0010, 1'b0, 16'h0, "rd_hit");
        idle(2);

        // Out of window for both completers: no memory access.
        cnt1 = en_cnt1;
        xfer(32'h0002_0005, 1'b0, 16'h0, "oow");
        idle(1);
        check("oow d1 no mem_en", en_cnt1, cnt1);
        check("oow pslverr cleared", {31'b0, pslverr1}, 32'h0);

        // Back-to-back write then read.
        cnt0 = en_cnt0;
        xfer(32'h0000_0003, 1'b1, 16'h1234, "b2b_wr");
        xfer(32'h0000_0003, 1'b0, 16'h0, "b2b_rd");
        idle(2);
        check("b2b mem_en pulses", en_cnt0 - cnt0, 2);

        // Window edges and aliasing.
        xfer(32'h0000_FFFF, 1'b1, 16'hA5A5, "d0_top_wr");
        xfer(32'h0000_FFFF, 1'b0, 16'h0, "d0_top_rd");
        cnt0 = en_cnt0;
        xfer(32'h0002_0010, 1'b0, 16'h0, "alias");
        idle(1);
        check("alias no mem_en", en_cnt0, cnt0);
        xfer(32'h0001_0007, 1'b1, 16'h5A5A, "d1_wr");
        xfer(32'h0001_FFFF, 1'b1, 16'h7777, "d1_top_wr");
        xfer(32'h0001_0007, 1'b0, 16'h0, "d1_rd");
        xfer(32'h0001_FFFF, 1'b0, 16'h0, "d1_top_rd");
        xfer(32'h0000_FFFF, 1'b0, 16'h0, "d1_below");
        xfer(32'h0002_0000, 1'b1, 16'h1111, "d1_above");
        xfer(32'h0000_0010, 1'b1, 16'hC3C3, "wr_holds_prdata");
        idle(2);

        // Access phase with no preceding setup is ignored.
        cnt0 = en_cnt0;
        cnt1 = en_cnt1;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; paddr = 32'h0000_0003; pwrite = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("stray penable pready", {31'b0, pready0 | pready1}, 32'h0);
        end
        idle(2);
        check("stray penable mem_en", (en_cnt0 - cnt0) + (en_cnt1 - cnt1), 0);

        // Abort a read in CAPT by dropping psel.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0010; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        last_rd[1] = 16'h0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort no pready", {31'b0, pready0}, 32'h0);
        end
        check("abort prdata held", {16'b0, prdata0}, {16'b0, last_rd[0]});

        // Reset while a read request is on the memory bus.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0003; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        check("rst_req mem_en before", {31'b0, mem_en0}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req mem_en async", {31'b0, mem_en0}, 32'h0);
        check("rst_req pready", {31'b0, pready0}, 32'h0);
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_req prdata", {16'b0, prdata0}, 32'h0);
        xfer(32'h0000_0003, 1'b0, 16'h0, "post_rst_rd");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
